// File: rtl/pipeline_ctrl_pkg.sv
// Shared definitions for the pipeline hazard controller: the controller state
// encoding and the default index and counter widths.
package pipeline_ctrl_pkg;

  // Default widths. Modules take these as parameter defaults.
  localparam int DEF_REG_W = 5;
  localparam int DEF_CNT_W = 16;

  // Controller states.
  //  RUN         : pipeline advancing normally
  //  FREEZE      : memory hold in progress, no branch is waiting
  //  FREEZE_PEND : memory hold in progress, a taken branch must flush on release
  typedef enum logic [1:0] {
    RUN         = 2'd0,
    FREEZE      = 2'd1,
    FREEZE_PEND = 2'd2
  } ctrl_state_t;

endpackage

// File: rtl/pipeline_hazard_controller_sat_counter.sv
// Saturating up-counter. It counts one per cycle while inc is high and sticks
// at all-ones. clr is synchronous and has priority over inc.
module sat_counter #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);

  logic [WIDTH-1:0] count_reg;

  // Count register: clear, or increment unless already saturated.
  always_ff @(posedge clk) begin
    if (clr) begin
      count_reg <= '0;
    end else if (inc && (count_reg != {WIDTH{1'b1}})) begin
      count_reg <= count_reg + WIDTH'(1);
    end
  end

  assign count = count_reg;

endmodule

// File: rtl/pipeline_hazard_controller.sv
// Central hazard control for the 5-stage pipeline. It drives the PC and
// pipeline-register write enables, the bubble-insert flush selects and the PC
// redirect select. It sequences load-use stalls, taken-branch flushes and memory
// freezes. A branch that arrives during a freeze is remembered and flushed on
// release. All controls are combinational from the state and the inputs.
module pipeline_hazard_controller
  import pipeline_ctrl_pkg::*;
#(
  parameter int REG_W   = DEF_REG_W,
  parameter int CNT_W   = DEF_CNT_W,
  parameter int TIMEOUT = 255
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             hold_req,
  input  logic             branch_taken,
  input  logic             idex_memread,
  input  logic [REG_W-1:0] idex_rd,
  input  logic [REG_W-1:0] ifid_rs1,
  input  logic [REG_W-1:0] ifid_rs2,
  input  logic             ifid_use_rs1,
  input  logic             ifid_use_rs2,
  output logic             pc_en,
  output logic             ifid_en,
  output logic             idex_en,
  output logic             exmem_en,
  output logic             memwb_en,
  output logic             ifid_flush,
  output logic             idex_flush,
  output logic             exmem_flush,
  output logic             redirect,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt,
  output logic             timeout_err
);

  ctrl_state_t state_reg, state_next;
  logic        luh;
  logic        stall_inc;
  logic        flush_inc;

  // Load-use hazard: a load in EX writes a register that ID really reads. x0 never counts.
  assign luh = idex_memread && (idex_rd != '0) &&
               ((ifid_use_rs1 && (ifid_rs1 == idex_rd)) ||
                (ifid_use_rs2 && (ifid_rs2 == idex_rd)));

  // State register. Reset drops any pending flush.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= RUN;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next state and controls. Priority: reset > freeze > flush > load-use > normal.
  always_comb begin
    state_next  = state_reg;
    pc_en       = 1'b1;
    ifid_en     = 1'b1;
    idex_en     = 1'b1;
    exmem_en    = 1'b1;
    memwb_en    = 1'b1;
    ifid_flush  = 1'b0;
    idex_flush  = 1'b0;
    exmem_flush = 1'b0;
    redirect    = 1'b0;
    stall_inc   = 1'b0;
    flush_inc   = 1'b0;

    if (rst) begin
      // Registers stay enabled so that every stage loads a bubble.
      ifid_flush  = 1'b1;
      idex_flush  = 1'b1;
      exmem_flush = 1'b1;
      state_next  = RUN;
    end else if (hold_req) begin
      // Freeze everything. Remember a taken branch so it flushes on release.
      pc_en    = 1'b0;
      ifid_en  = 1'b0;
      idex_en  = 1'b0;
      exmem_en = 1'b0;
      memwb_en = 1'b0;
      if (branch_taken || (state_reg == FREEZE_PEND)) begin
        state_next = FREEZE_PEND;
      end else begin
        state_next = FREEZE;
      end
    end else begin
      // RUN, or the release cycle of a freeze, which behaves like RUN.
      state_next = RUN;
      if (branch_taken || (state_reg == FREEZE_PEND)) begin
        // The target is still in EX/MEM because that register was frozen.
        // The ID instruction gets squashed, so a load-use hazard does not matter here.
        ifid_flush  = 1'b1;
        idex_flush  = 1'b1;
        exmem_flush = 1'b1;
        redirect    = 1'b1;
        flush_inc   = 1'b1;
      end else if (luh) begin
        // Hold PC and IF/ID for one cycle and put a bubble in EX. The bubble
        // clears idex_memread, so the hazard is gone on the next cycle.
        pc_en      = 1'b0;
        ifid_en    = 1'b0;
        idex_flush = 1'b1;
        stall_inc  = 1'b1;
      end
    end
  end

  sat_counter #(.WIDTH(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .clr   (rst),
    .inc   (stall_inc),
    .count (stall_cnt)
  );

  sat_counter #(.WIDTH(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .clr   (rst),
    .inc   (flush_inc),
    .count (flush_cnt)
  );

  generate
    if (TIMEOUT > 0) begin : g_watchdog
      localparam int FRZ_W = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
      localparam logic [FRZ_W-1:0] FRZ_MAX = FRZ_W'(TIMEOUT);

      logic [FRZ_W-1:0] frz_cnt_reg, frz_cnt_next;
      logic             timeout_err_reg;
      logic             wd_fire;

      // Count consecutive hold cycles, stop at the limit and clear on any free cycle.
      always_comb begin
        frz_cnt_next = '0;
        if (hold_req) begin
          frz_cnt_next = (frz_cnt_reg == FRZ_MAX) ? frz_cnt_reg : frz_cnt_reg + FRZ_W'(1);
        end
      end

      assign wd_fire = hold_req && (frz_cnt_next == FRZ_MAX);

      // Freeze-length counter and sticky timeout flag. The flag only reports; it never ends a freeze.
      always_ff @(posedge clk) begin
        if (rst) begin
          frz_cnt_reg     <= '0;
          timeout_err_reg <= 1'b0;
        end else begin
          frz_cnt_reg <= frz_cnt_next;
          if (wd_fire) begin
            timeout_err_reg <= 1'b1;
          end
        end
      end

      assign timeout_err = timeout_err_reg;
    end else begin : g_no_watchdog
      assign timeout_err = 1'b0;
    end
  endgenerate

endmodule
